// File: rtl/rom_fetch_unit.sv
// rtl/rom_fetch_unit.sv - byte-wide ROM fetch stage packing little-endian 32-bit instruction words
// Four FETCH cycles fill one word; HOLD presents it with valid/ready; redirect overrides everything.
module rom_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          ROM_BYTES = 16
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        fetch_en,
  output logic [31:0] rom_addr,
  input  logic [7:0]  rom_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [23:0] asm_q, asm_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic        instr_valid_q, instr_valid_d;

  logic [31:0] pc_plus4;
  logic [31:0] next_pc;
  logic [31:0] redirect_target;

  assign pc_plus4        = pc_q + 32'd4;
  assign next_pc         = (pc_plus4 >= 32'(ROM_BYTES)) ? 32'd0 : pc_plus4;
  assign redirect_target = redirect_pc & ~32'h0000_0003;

  assign rom_addr    = pc_q + {30'd0, byte_idx_q};
  assign instr_valid = instr_valid_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    byte_idx_d    = byte_idx_q;
    asm_d         = asm_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;

    case (state_q)
      S_IDLE: begin
        if (fetch_en) state_d = S_FETCH;
      end
      S_FETCH: begin
        byte_idx_d = byte_idx_q + 2'd1;
        case (byte_idx_q)
          2'd0: asm_d[7:0]   = rom_data;
          2'd1: asm_d[15:8]  = rom_data;
          2'd2: asm_d[23:16] = rom_data;
          default: begin
            instr_d       = {rom_data, asm_q};
            instr_pc_d    = pc_q;
            instr_valid_d = 1'b1;
            pc_d          = next_pc;
            asm_d         = 24'd0;
            state_d       = S_HOLD;
          end
        endcase
      end
      S_HOLD: begin
        if (instr_valid_q && instr_ready) begin
          instr_valid_d = 1'b0;
          state_d       = fetch_en ? S_FETCH : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Redirect wins over a word completing this cycle; a word handed over this cycle is already gone.
    if (redirect_valid) begin
      pc_d          = redirect_target;
      byte_idx_d    = 2'd0;
      asm_d         = 24'd0;
      instr_d       = instr_q;
      instr_pc_d    = instr_pc_q;
      instr_valid_d = 1'b0;
      state_d       = fetch_en ? S_FETCH : S_IDLE;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      byte_idx_q    <= 2'd0;
      asm_q         <= 24'd0;
      instr_q       <= 32'd0;
      instr_pc_q    <= 32'd0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      byte_idx_q    <= byte_idx_d;
      asm_q         <= asm_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
    end
  end

endmodule

// File: tb/tb_rom_fetch_unit.sv
// tb/tb_rom_fetch_unit.sv - scoreboard bench for rom_fetch_unit with a 16-byte ROM holding byte n at address n
module tb_rom_fetch_unit;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b0;
  logic        fetch_en = 1'b0;
  logic [31:0] rom_addr;
  logic [7:0]  rom_data;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        instr_valid;
  logic        instr_ready = 1'b1;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  int n_checks = 0;
  int n_fails  = 0;
  int n_pops   = 0;

  logic [31:0] exp_instr_q[$];
  logic [31:0] exp_pc_q[$];

  always #5 sys_clk = ~sys_clk;

  assign rom_data = (rom_addr < 32'd16) ? rom_addr[7:0] : 8'hEE;

  rom_fetch_unit #(.RESET_PC(32'h0000_0000), .ROM_BYTES(16)) dut (
    .sys_clk        (sys_clk),
    .sys_rst        (sys_rst),
    .fetch_en       (fetch_en),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  task automatic expect_word(input logic [31:0] w, input logic [31:0] pc);
    exp_instr_q.push_back(w);
    exp_pc_q.push_back(pc);
  endtask

  // Monitor: every accepted handshake must match the head of the scoreboard.
  always @(negedge sys_clk) begin
    if (sys_rst && instr_valid && instr_ready) begin
      if (exp_instr_q.size() == 0) begin
        chk("unexpected_word", instr, 32'hDEAD_BEEF);
      end else begin
        chk("sb_instr", instr, exp_instr_q.pop_front());
        chk("sb_instr_pc", instr_pc, exp_pc_q.pop_front());
      end
      n_pops++;
    end
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic do_reset(input logic en);
    sys_rst        = 1'b0;
    fetch_en       = 1'b0;
    redirect_valid = 1'b0;
    tick();
    tick();
    fetch_en = en;
    sys_rst  = 1'b1;
  endtask

  // Waits just past a negedge so the caller can change inputs before the accepting edge.
  task automatic wait_pops(input int target, input string name);
    int budget;
    budget = 60;
    while (n_pops < target && budget > 0) begin
      @(negedge sys_clk);
      #1;
      budget--;
    end
    if (n_pops < target) chk({name, "_timeout"}, 32'(n_pops), 32'(target));
  endtask

  initial begin
    // Reset state and nominal streaming
    sys_rst = 1'b0;
    tick();
    tick();
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_instr_pc", instr_pc, 32'd0);
    chk("rst_rom_addr", rom_addr, 32'd0);
    expect_word(32'h03020100, 32'd0);
    expect_word(32'h07060504, 32'd4);
    expect_word(32'h0B0A0908, 32'd8);
    expect_word(32'h0F0E0D0C, 32'd12);
    expect_word(32'h03020100, 32'd0);
    n_pops = 0;
    fetch_en    = 1'b1;
    instr_ready = 1'b1;
    sys_rst     = 1'b1;
    for (int e = 1; e <= 25; e++) begin
      tick();
      chk($sformatf("valid_edge%0d", e), {31'd0, instr_valid}, (e % 5 == 0) ? 32'd1 : 32'd0);
      if (e == 25) fetch_en = 1'b0;
    end
    tick();
    chk("idle_valid", {31'd0, instr_valid}, 32'd0);
    chk("idle_rom_addr", rom_addr, 32'd4);
    for (int i = 0; i < 6; i++) tick();
    chk("idle_still_valid", {31'd0, instr_valid}, 32'd0);
    chk("idle_still_rom_addr", rom_addr, 32'd4);
    chk("stream_pops", 32'(n_pops), 32'd5);

    // Backpressure on the first word
    n_pops = 0;
    instr_ready = 1'b0;
    do_reset(1'b1);
    expect_word(32'h03020100, 32'd0);
    expect_word(32'h07060504, 32'd4);
    for (int i = 0; i < 5; i++) tick();
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", {31'd0, instr_valid}, 32'd1);
      chk("bp_instr", instr, 32'h03020100);
      chk("bp_instr_pc", instr_pc, 32'd0);
      chk("bp_rom_addr", rom_addr, 32'd4);
      tick();
    end
    instr_ready = 1'b1;
    wait_pops(2, "bp");
    fetch_en = 1'b0;
    tick();

    // Redirect mid-word (byte_idx=2) to an unaligned target
    n_pops = 0;
    do_reset(1'b1);
    expect_word(32'h0B0A0908, 32'd8);
    for (int i = 0; i < 3; i++) tick();
    chk("mid_rom_addr", rom_addr, 32'd2);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_000B;
    tick();
    redirect_valid = 1'b0;
    chk("redir_rom_addr", rom_addr, 32'd8);
    wait_pops(1, "redir_mid");
    fetch_en = 1'b0;
    tick();

    // Redirect while holding an unaccepted word
    n_pops = 0;
    instr_ready = 1'b0;
    do_reset(1'b1);
    expect_word(32'h07060504, 32'd4);
    for (int i = 0; i < 5; i++) tick();
    chk("hold_valid", {31'd0, instr_valid}, 32'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'd4;
    tick();
    redirect_valid = 1'b0;
    chk("hold_redir_valid", {31'd0, instr_valid}, 32'd0);
    chk("hold_redir_rom_addr", rom_addr, 32'd4);
    instr_ready = 1'b1;
    wait_pops(1, "redir_hold");
    fetch_en = 1'b0;
    tick();

    // Redirect in the same cycle as the accept
    n_pops = 0;
    do_reset(1'b1);
    expect_word(32'h03020100, 32'd0);
    expect_word(32'h07060504, 32'd4);
    for (int i = 0; i < 5; i++) tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'd4;
    tick();
    redirect_valid = 1'b0;
    chk("same_redir_valid", {31'd0, instr_valid}, 32'd0);
    chk("same_redir_rom_addr", rom_addr, 32'd4);
    wait_pops(2, "redir_same");
    fetch_en = 1'b0;
    tick();

    // Asynchronous reset between edges mid-FETCH
    n_pops = 0;
    do_reset(1'b1);
    for (int i = 0; i < 3; i++) tick();
    #2;
    sys_rst = 1'b0;
    #1;
    chk("async_valid", {31'd0, instr_valid}, 32'd0);
    chk("async_rom_addr", rom_addr, 32'd0);
    expect_word(32'h03020100, 32'd0);
    sys_rst = 1'b1;
    wait_pops(1, "async");
    fetch_en = 1'b0;
    tick();
    tick();

    chk("sb_empty", 32'(exp_instr_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/rom_fetch_unit.md
# rom_fetch_unit

Fetch stage that drives the byte-wide ROM and packs its output into 32-bit instruction words for the CPU decode stage. Each cycle it puts an address on the ROM address bus and captures the returned byte. Every four bytes are assembled little-endian into one word. The word is presented downstream with a valid/ready handshake, and the fetch stream can be redirected for jumps and branches.

## Interface
- RESET_PC, 32'h0000_0000, fetch address loaded at reset; must be 4-aligned.
- ROM_BYTES, 16, ROM size in bytes; a multiple of 4, at least 4.
- sys_clk  in  1  single clock; all state updates on its rising edge.
- sys_rst  in  1  reset, asynchronous, active-low.
- fetch_en  in  1  when high, the unit may start a new word.
- rom_addr  out  32  byte address to ROM; combinational from internal registers, equal to pc + byte_idx.
- rom_data  in  8  ROM byte for rom_addr, valid in the same cycle (combinational ROM).
- redirect_valid  in  1  jump request; single-cycle pulse.
- redirect_pc  in  32  jump target; bits [1:0] are ignored and treated as 0.
- instr_valid  out  1  instr and instr_pc hold a complete word.
- instr_ready  in  1  consumer accepts the word.
- instr  out  32  assembled word; the byte at instr_pc sits in [7:0].
- instr_pc  out  32  address of byte 0 of instr.

## Operation
- Registers: pc[31:0], byte_idx[1:0], asm[23:0] for partial bytes, state.
- States and transitions:
  - IDLE: go to FETCH when fetch_en=1.
  - FETCH: each cycle capture rom_data into byte lane byte_idx, then byte_idx++.
    - On the cycle with byte_idx=3: instr <= {rom_data, asm}, instr_pc <= pc, instr_valid <= 1, pc <= next_pc, go to HOLD.
  - HOLD: wait for instr_valid && instr_ready.
    - On accept: instr_valid <= 0; go to FETCH if fetch_en=1, else IDLE.
- next_pc = pc + 4, or 0 when pc + 4 >= ROM_BYTES (wrap-around). Arithmetic is 32-bit unsigned.
- rom_addr is still driven in IDLE and HOLD (= pc + byte_idx), but the byte is not captured.
- fetch_en is sampled only when leaving IDLE or HOLD. A word already in progress always completes.
- Redirect, in any state: pc <= {redirect_pc[31:2], 2'b00}, byte_idx <= 0, partial bytes discarded.
  - A held word still present is dropped (instr_valid <= 0).
  - Next state is FETCH if fetch_en=1, else IDLE.
- Redirect and handshake in the same cycle: the handshake completes, so the consumer owns that word. The redirect still applies.
- Redirect on the FETCH byte_idx=3 cycle: the word is discarded and instr_valid stays 0. Redirect wins.
- instr and instr_pc stay stable while instr_valid=1 and instr_ready=0.
- Reset (asynchronous, any time, including mid-word):
  - IDLE, pc=RESET_PC, byte_idx=0, asm=0.
  - instr_valid=0, instr=0, instr_pc=0, hence rom_addr=RESET_PC.

## Timing
- Latency: with fetch_en=1, a word takes 1 IDLE→FETCH cycle plus 4 FETCH cycles. instr_valid rises on the 5th rising edge after reset release.
- Throughput with instr_ready held at 1: one word every 5 cycles (4 FETCH + 1 HOLD).
- Redirect takes effect on the edge where it is sampled. rom_addr = target from the next cycle.
- No combinational path from instr_ready or redirect_valid to any output.

## Test plan
All scenarios use ROM byte n = 8'hn for n = 0..15, RESET_PC=0, ROM_BYTES=16.
- Reset, then fetch_en=1, instr_ready=1:
  - words 32'h03020100 @0, 32'h07060504 @4, 32'h0B0A0908 @8, 32'h0F0E0D0C @12, then 32'h03020100 @0 (wrap).
  - First instr_valid on edge 5; 5-cycle spacing between words.
- Backpressure: instr_ready=0 for 10 cycles on the first word.
  - instr stays 32'h03020100, instr_pc stays 0, rom_addr stays 4, and no new bytes are captured.
  - On release, the next word 32'h07060504 follows.
- Redirect to 32'h0000_000B mid-word (byte_idx=2): partial word dropped, rom_addr=8 on the next cycle, next word 32'h0B0A0908 @8.
- Redirect to 4 while holding an unaccepted word: instr_valid falls. Same-cycle redirect + accept: the accepted word counts. Either way, the next word is 32'h07060504 @4.
- fetch_en=0 while in HOLD: after accept, the unit goes to IDLE with no further words and rom_addr stays at next_pc.
- Async reset asserted mid-FETCH, between edges: instr_valid=0 and rom_addr=0 immediately. After release, the first word is 32'h03020100.
